// File: rtl/program_loader.sv
// program_loader: byte-stream loader that writes 16-bit instructions into program memory and gates the CPU reset.
// Latency: hi byte accepted at edge k -> write strobe in cycle k+1; checksum accepted at edge k -> done/error in cycle k+1.
// Backpressure: byteReady is low in IDLE, WRITE, DONE and ERR, so at most 2 bytes are taken every 3 cycles.
//
// Ports:
//   clock, reset          system clock, synchronous active-low reset
//   start                 level request to begin a load (seen only in IDLE/DONE/ERR)
//   byteIn/Valid/Ready    stream input handshake; a byte moves when byteValid && byteReady at a rising edge
//   memWriteEnable        one-cycle write strobe, with memAddress/memData valid in the same cycle
//   cpuReset              active-low reset to the mini computer, released only in DONE
//   busy/done/error       session status levels
//
// Frame: N, then N+1 words sent lo byte then hi byte, then an XOR checksum over N and every data byte.

module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byteIn,
  input  logic                  byteValid,
  output logic                  byteReady,
  output logic                  memWriteEnable,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memData,
  output logic                  cpuReset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // One extra bit so that N=0xFF can count through all 256 words without wrapping.
  localparam int CNT_WIDTH = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LO,
    S_HI,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t               state;
  logic [7:0]           frame_len;
  logic [CNT_WIDTH-1:0] word_count;
  logic [7:0]           low_byte;
  logic [7:0]           checksum;
  logic                 accept;

  // Ready depends on the state register alone, never on byteValid or start.
  assign byteReady = (state == S_LEN) || (state == S_LO) ||
                     (state == S_HI)  || (state == S_CHK);

  assign accept = byteValid && byteReady;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= S_IDLE;
      frame_len      <= 8'h00;
      word_count     <= '0;
      low_byte       <= 8'h00;
      checksum       <= 8'h00;
      memWriteEnable <= 1'b0;
      memAddress     <= '0;
      memData        <= '0;
      cpuReset       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      // The write strobe is only ever raised for the single WRITE cycle.
      memWriteEnable <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LEN;
            busy     <= 1'b1;
            checksum <= 8'h00;
          end
        end

        S_LEN: begin
          if (accept) begin
            frame_len  <= byteIn;
            checksum   <= byteIn;  // checksum was cleared entering LEN
            word_count <= '0;
            memAddress <= '0;
            state      <= S_LO;
          end
        end

        S_LO: begin
          if (accept) begin
            low_byte <= byteIn;
            checksum <= checksum ^ byteIn;
            state    <= S_HI;
          end
        end

        S_HI: begin
          if (accept) begin
            memData        <= DATA_WIDTH'({byteIn, low_byte});
            memAddress     <= word_count[ADDR_WIDTH-1:0];
            memWriteEnable <= 1'b1;
            checksum       <= checksum ^ byteIn;
            state          <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (word_count == CNT_WIDTH'(frame_len)) begin
            state <= S_CHK;
          end else begin
            word_count <= word_count + 1'b1;
            state      <= S_LO;
          end
        end

        S_CHK: begin
          if (accept) begin
            busy <= 1'b0;
            if (byteIn == checksum) begin
              done     <= 1'b1;
              cpuReset <= 1'b1;
              state    <= S_DONE;
            end else begin
              error <= 1'b1;
              state <= S_ERR;
            end
          end
        end

        S_DONE, S_ERR: begin
          // A new session clears the previous result and re-holds the CPU on the same edge.
          if (start) begin
            done     <= 1'b0;
            error    <= 1'b0;
            cpuReset <= 1'b0;
            busy     <= 1'b1;
            checksum <= 8'h00;
            state    <= S_LEN;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byteIn = 8'h00;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic        memWriteEnable;
  logic [7:0]  memAddress;
  logic [15:0] memData;
  logic        cpuReset;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clock = ~clock;

  program_loader dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .byteIn         (byteIn),
    .byteValid      (byteValid),
    .byteReady      (byteReady),
    .memWriteEnable (memWriteEnable),
    .memAddress     (memAddress),
    .memData        (memData),
    .cpuReset       (cpuReset),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] wbuf[256];
  int          checks = 0;
  int          fails = 0;
  int          strobe_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the next queued write, and ready must be low.
  always @(negedge clock) begin
    if (memWriteEnable) begin
      wr_t w;
      strobe_count++;
      chk("ready_low_in_write", {31'd0, byteReady}, 32'd0);
      chk("strobe_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("wr_addr", {24'd0, memAddress}, {24'd0, w.addr});
        chk("wr_data", {16'd0, memData}, {16'd0, w.data});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    int n;
    if (gap > 0) begin
      @(negedge clock);
      byteValid = 1'b0;
      repeat (gap - 1) @(negedge clock);
    end
    @(negedge clock);
    byteIn    = b;
    byteValid = 1'b1;
    start     = with_start;
    n = 0;
    while (!byteReady && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("ready_wait", {31'd0, n < 50}, 32'd1);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  function automatic int pick_gap(input bit rnd);
    return rnd ? int'($urandom_range(0, 3)) : 0;
  endfunction

  // Queues the expected writes from wbuf[0..n], then streams the frame with the given checksum.
  task automatic send_frame(input logic [7:0] n, input bit rnd, input bit pulses, input logic [7:0] csum);
    for (int i = 0; i <= int'(n); i++) begin
      exp_q.push_back('{addr: i[7:0], data: wbuf[i]});
    end
    send_byte(n, pick_gap(rnd), 1'b0);
    for (int i = 0; i <= int'(n); i++) begin
      send_byte(wbuf[i][7:0], pick_gap(rnd), pulses && (i == 1));
      send_byte(wbuf[i][15:8], pick_gap(rnd), pulses && (i == 0));
    end
    send_byte(csum, pick_gap(rnd), 1'b0);
  endtask

  task automatic check_status(input logic exp_done, input logic exp_err);
    @(negedge clock);
    byteValid = 1'b0;
    chk("done", {31'd0, done}, {31'd0, exp_done});
    chk("error", {31'd0, error}, {31'd0, exp_err});
    chk("cpuReset", {31'd0, cpuReset}, {31'd0, exp_done});
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("ready_end", {31'd0, byteReady}, 32'd0);
    chk("all_writes_seen", exp_q.size(), 32'd0);
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, {31'd0, byteReady}, 32'd0);
    chk({tag, "_we"}, {31'd0, memWriteEnable}, 32'd0);
    chk({tag, "_addr"}, {24'd0, memAddress}, 32'd0);
    chk({tag, "_data"}, {16'd0, memData}, 32'd0);
    chk({tag, "_cpuReset"}, {31'd0, cpuReset}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    int s0;

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values("rst");
    reset = 1'b1;

    // Nominal frame 01,34,12,CD,AB,41.
    wbuf[0] = 16'h1234;
    wbuf[1] = 16'hABCD;
    do_start();
    chk("start_ready", {31'd0, byteReady}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
    s0 = strobe_count;
    send_frame(8'h01, 1'b0, 1'b0, 8'h41);
    check_status(1'b1, 1'b0);
    chk("nominal_strobes", strobe_count - s0, 32'd2);

    // Bad checksum: writes still happen, CPU stays held.
    do_start();
    chk("restart_cpuReset", {31'd0, cpuReset}, 32'd0);
    chk("restart_done", {31'd0, done}, 32'd0);
    s0 = strobe_count;
    send_frame(8'h01, 1'b0, 1'b0, 8'h00);
    check_status(1'b0, 1'b1);
    chk("bad_strobes", strobe_count - s0, 32'd2);

    // Recovery from ERR with the correct frame.
    do_start();
    chk("err_restart_error", {31'd0, error}, 32'd0);
    chk("err_restart_ready", {31'd0, byteReady}, 32'd1);
    send_frame(8'h01, 1'b0, 1'b0, 8'h41);
    check_status(1'b1, 1'b0);

    // Same frame with random gaps in byteValid.
    do_start();
    send_frame(8'h01, 1'b1, 1'b0, 8'h41);
    check_status(1'b1, 1'b0);

    // Reset on the edge that would accept the hi byte: no strobe, all outputs back to reset values.
    do_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    s0 = strobe_count;
    @(negedge clock);
    byteIn    = 8'h12;
    byteValid = 1'b1;
    reset     = 1'b0;
    @(negedge clock);
    check_reset_values("midrst");
    chk("midrst_strobes", strobe_count - s0, 32'd0);
    reset     = 1'b1;
    byteValid = 1'b0;

    // Full depth: word i = {~i, i}; checksum FF ^ (256 x FF) = FF.
    for (int i = 0; i < 256; i++) begin
      wbuf[i] = {~i[7:0], i[7:0]};
    end
    do_start();
    s0 = strobe_count;
    send_frame(8'hFF, 1'b0, 1'b0, 8'hFF);
    check_status(1'b1, 1'b0);
    chk("full_strobes", strobe_count - s0, 32'd256);
    chk("full_last_data", {16'd0, memData}, 32'h00FF);
    chk("full_last_addr", {24'd0, memAddress}, 32'hFF);

    // start pulses during LO/HI are ignored; checksum 02^11^11^22^22^44^33 = 75.
    wbuf[0] = 16'h1111;
    wbuf[1] = 16'h2222;
    wbuf[2] = 16'h3344;
    do_start();
    send_frame(8'h02, 1'b0, 1'b1, 8'h75);
    check_status(1'b1, 1'b0);

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader for the mini computer. Accepts a framed byte stream (length, instruction words low byte first, XOR checksum) over a valid/ready handshake. Writes each assembled 16-bit instruction into a writable program memory at consecutive addresses starting at 0. Holds the CPU in reset until a load completes with a correct checksum, so it is the writer counterpart to the CPU's program-memory instruction fetch.

## Interface
Parameters:
- ADDR_WIDTH, 8, program memory address width (256 words)
- DATA_WIDTH, 16, instruction width; fixed at two bytes

Ports:
- clock  in  1  single system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- start  in  1  level-sampled request to begin a load session
- byteIn  in  8  stream data byte
- byteValid  in  1  byteIn valid
- byteReady  out  1  loader can accept byte; decoded from state register only
- memWriteEnable  out  1  one-cycle write strobe to program memory
- memAddress  out  8  write address, registered
- memData  out  16  write data {high byte, low byte}, registered
- cpuReset  out  1  active-low reset driven to the mini computer
- busy  out  1  high from LEN through CHK
- done  out  1  load completed, checksum matched (level)
- error  out  1  checksum mismatch (level)

## Operation
- Transfer: a byte is consumed on a rising edge where byteValid && byteReady. byteIn must be held stable while byteValid=1 && byteReady=0.
- Frame format: N, then (N+1) words as lo,hi byte pairs, then checksum C. N ranges 0x00–0xFF, giving 1–256 words.
- Checksum: running 8-bit XOR of N and every data byte. It is cleared on entry to LEN.
- States and transitions:
  - IDLE: byteReady=0. On start=1, go to LEN.
  - LEN: byteReady=1. On accept, latch N, clear the word counter and address, go to LO.
  - LO: byteReady=1. On accept, latch the low byte, go to HI.
  - HI: byteReady=1. On accept, load memData={byteIn, lowByte} and memAddress=wordCount, go to WRITE.
  - WRITE: byteReady=0 and memWriteEnable=1 for exactly this cycle. Then:
    - if wordCount==N, go to CHK;
    - else increment wordCount and go to LO.
  - CHK: byteReady=1. On accept:
    - C==running XOR: go to DONE;
    - otherwise go to ERR.
  - DONE: done=1, cpuReset=1. On start=1, go to LEN.
  - ERR: error=1, cpuReset=0. On start=1, go to LEN.
- cpuReset is 0 in every state except DONE.
- start is ignored in LEN, LO, HI, WRITE and CHK; it does not restart the frame.
- Entering LEN from DONE or ERR clears done and error in the same edge and drives cpuReset to 0.
- Word counter is 9 bits internally. N=0xFF writes addresses 0x00–0xFF with no wrap before CHK.
- No write occurs in CHK, DONE or ERR. A bad checksum does not roll back words already written.

## Timing
- Reset values (reset=0 at an edge): state IDLE, byteReady=0, memWriteEnable=0, memAddress=0x00, memData=0x0000, cpuReset=0, busy=0, done=0, error=0, checksum=0x00.
- Reset mid-frame takes effect on that edge. The partial frame is abandoned, and no write strobe is issued for a pending word.
- start sampled at edge k in IDLE: byteReady=1 from cycle k+1.
- Hi byte accepted at edge k: memWriteEnable=1 during cycle k+1, with address and data valid in that same cycle. Next byte accepted no earlier than edge k+2.
- Maximum throughput is 2 bytes per 3 cycles. A full 256-word frame with back-to-back valid takes 1+1+768+1 cycles from start to DONE.
- Checksum accepted at edge k: done=1 (or error=1) and cpuReset=1 (DONE only) during cycle k+1.

## Test plan
- Nominal: reset, start, stream 01,34,12,CD,AB,41 -> write 0x1234@0x00 and 0xABCD@0x01, exactly two strobes, then done=1, cpuReset=1, error=0.
- Bad checksum: same frame with C=0x00 -> two writes occur, then error=1, done=0, cpuReset stays 0. A following start plus the correct frame -> done=1, error=0.
- Backpressure: byteValid held high continuously -> byteReady=0 during each WRITE cycle and no byte is lost or duplicated. Random gaps in byteValid -> identical memory contents.
- Full depth: N=0xFF with data word i = {~i[7:0], i[7:0]} -> 256 strobes, addresses 0x00..0xFF in order, last data 0x00FF, correct C -> done=1.
- Reset mid-operation: reset=0 on the edge accepting a hi byte -> no strobe, all outputs at reset values next cycle. A new start with a full frame completes normally from address 0.
- start pulses during LO/HI are ignored, with no restart and the address sequence intact. start in DONE -> cpuReset=0 and done=0 on the next cycle, and a new frame is accepted.
